// File: rtl/regbank_sequencer.sv
// Program-memory sequencer that drives the register-bank/ALU datapath with load and ALU transactions.
// Optional build macro SINGLE_STEP_EN adds a 'step' input and a PAUSE state between instructions.
module regbank_sequencer #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic          start,
`ifdef SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic          load,
  output logic [31:0]   din,
  output logic [3:0]    op,
  output logic [3:0]    rs1,
  output logic [3:0]    rs2,
  output logic [3:0]    rd,
  input  logic [31:0]   out,
  output logic [31:0]   last_result
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_FETCH_IMM, S_ISSUE, S_RETIRE, S_DONE
`ifdef SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t          r_state, w_next;
  logic [31:0]     r_mem [DEPTH];
  logic [31:0]     r_rdata;
  logic [17:0]     r_hdr;
  logic [AW-1:0]   r_pc;
  logic            r_err;
  logic [31:0]     r_last;
  logic [HW-1:0]   r_hold;

  logic            w_hdr_load;
  logic [AW:0]     w_pc_inc;
  logic [AW:0]     w_imm_addr;
  logic [AW-1:0]   w_raddr;
  logic            w_rd_en;
  logic            w_issue;

  assign w_hdr_load = r_hdr[17];
  // The carry bit of these sums flags a walk past the last memory word.
  assign w_pc_inc   = {1'b0, r_pc} + {{(AW-1){1'b0}}, w_hdr_load, ~w_hdr_load};
  assign w_imm_addr = {1'b0, r_pc} + {{AW{1'b0}}, 1'b1};
  assign w_raddr    = (r_state == S_FETCH_IMM) ? w_imm_addr[AW-1:0] : r_pc;
  assign w_rd_en    = (r_state == S_FETCH) || ((r_state == S_FETCH_IMM) && !w_imm_addr[AW]);
  assign w_issue    = (r_state == S_ISSUE);

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;
  assign pc          = r_pc;
  assign last_result = r_last;

  // Program memory: writes only while idle; read data stays put until the next fetch.
  always_ff @(posedge clk) begin
    if (prog_we && (r_state == S_IDLE))
      r_mem[prog_addr] <= prog_data;
    if (w_rd_en)
      r_rdata <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (r_state == S_DECODE)
      r_hdr <= r_rdata[31:14];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    load   = 1'b0;
    din    = 32'd0;
    op     = 4'd0;
    rs1    = 4'd0;
    rs2    = 4'd0;
    rd     = 4'd0;
    case (r_state)
      S_IDLE:      if (start) w_next = S_FETCH;
      S_FETCH:     w_next = S_DECODE;
      S_DECODE: begin
        if (r_rdata[14])      w_next = S_DONE;
        else if (r_rdata[31]) w_next = S_FETCH_IMM;
        else                  w_next = S_ISSUE;
      end
      S_FETCH_IMM: w_next = w_imm_addr[AW] ? S_DONE : S_ISSUE;
      S_ISSUE:     if (r_hold == HOLD_LAST) w_next = S_RETIRE;
      S_RETIRE: begin
`ifdef SINGLE_STEP_EN
        w_next = w_pc_inc[AW] ? S_DONE : S_PAUSE;
`else
        w_next = w_pc_inc[AW] ? S_DONE : S_FETCH;
`endif
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE:     if (step) w_next = S_FETCH;
`endif
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (w_issue) begin
      load = w_hdr_load;
      rd   = r_hdr[12:9];
      if (w_hdr_load) begin
        din = r_rdata;
      end else begin
        op  = r_hdr[16:13];
        rs1 = r_hdr[8:5];
        rs2 = r_hdr[4:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_err  <= 1'b0;
      r_last <= 32'd0;
      r_hold <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc  <= '0;
            r_err <= 1'b0;
          end
        end
        S_FETCH_IMM: if (w_imm_addr[AW]) r_err <= 1'b1;
        S_ISSUE:     r_hold <= (r_hold == HOLD_LAST) ? '0 : r_hold + HW'(1);
        S_RETIRE: begin
          if (!w_hdr_load) r_last <= out;
          if (w_pc_inc[AW]) r_err <= 1'b1;
          else              r_pc  <= w_pc_inc[AW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
- Initiator side of the register-bank/ALU datapath interface (`din`/`load`/`op`/`rs1`/`rs2`/`rd`/`out`).
- Holds a small writable program memory and executes it in order, driving the datapath with load-immediate and ALU-op transactions.
- Captures the datapath result after each ALU op.
- Replaces hand-driven stimulus as the datapath's control source.

Parameters:
- DEPTH, 16, program memory words (power of two, ≥4).
- AW, 4, program address width = log2(DEPTH).
- HOLD_CYCLES, 2, cycles each transaction is held stable on the datapath (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program memory write strobe; honoured only when not busy.
- prog_addr  in  AW  program write address.
- prog_data  in  32  program write data.
- start  in  1  begin execution at address 0; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE exits.
- done  out  1  one-cycle pulse at end of program.
- err  out  1  sticky: program ran off end of memory; cleared by the next accepted start or by rst.
- pc  out  AW  address of the current header word.
- load  out  1  to datapath: 1 = write din to rd; 0 = ALU op rd = rs1 op rs2.
- din  out  32  immediate for a load transaction.
- op  out  4  ALU opcode.
- rs1, rs2, rd  out  4  register indices.
- out  in  32  datapath result bus.
- last_result  out  32  out sampled at the end of the most recent ALU transaction.

Behaviour:
- Instruction header word fields:
  - [31] is_load
  - [30:27] op
  - [26:23] rd
  - [22:19] rs1
  - [18:15] rs2
  - [14] halt
  - [13:0] reserved, ignored
- If is_load=1, the next word is the 32-bit immediate and pc advances by 2; otherwise pc advances by 1.
- Memory read is synchronous (1-cycle latency).
- FSM states and transitions:
  - IDLE: start → FETCH, pc=0.
  - FETCH: memory address = pc.
  - DECODE: latch the header. If halt=1 → DONE (nothing issued). If is_load=1 → FETCH_IMM. Otherwise → ISSUE.
  - FETCH_IMM: if pc+1 ≥ DEPTH, set err and go to DONE. Otherwise read pc+1, latch din, → ISSUE.
  - ISSUE: drive fields for exactly HOLD_CYCLES cycles, then → RETIRE.
  - RETIRE: if the transaction was an ALU op, last_result ← out. Advance pc. If the new pc ≥ DEPTH (wrap detected via a carry bit), set err and go to DONE; otherwise → FETCH.
  - DONE: done=1 for one cycle, → IDLE.
- Datapath outputs outside ISSUE: load=0, op=0, rs1=rs2=rd=0, din=0. These are never X or Z.
- During ISSUE:
  - Load transaction: op=0, rs1=rs2=0.
  - ALU transaction: din=0.
- Per-instruction latency: 2+HOLD_CYCLES+1 cycles for an ALU op; 3+HOLD_CYCLES+1 cycles for a load.
- start while busy: ignored.
- prog_we while busy: ignored, memory unchanged.
- prog_we and start in the same IDLE cycle: the write takes effect first; execution sees the new word.
- Reset values: busy=0, done=0, err=0, pc=0, last_result=0, all datapath outputs 0, FSM=IDLE. Program memory is not reset.
- rst mid-program: abort in the same edge, no further datapath transaction, done not pulsed.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - After RETIRE (unless going to DONE), the FSM enters PAUSE with all datapath outputs 0 and busy=1.
  - A one-cycle step=1 → FETCH. step held high advances one instruction per PAUSE entry.
  - step in any other state is ignored.
- Undefined: no step port, no PAUSE state; RETIRE goes directly to FETCH.

Test Plan:
- Program: LOAD r1=20, LOAD r2=10, LOAD r3=50, op1 r5=r1,r2, halt; start → three load transactions each held HOLD_CYCLES with load=1 and din=20/10/50, rd=1/2/3. Then ALU transaction with load=0, op=1, rs1=1, rs2=2, rd=5. last_result=out value (30 with a reference ALU model). done pulses once, busy falls.
- Program: op2 r6=r3,r2 then op3 r7=r1,r2 then halt → two ALU transactions in order; pc sequence 0,1,2; last_result updates after each; din=0 throughout.
- Halt at address 0 → no datapath transaction (load stays 0); done pulses 3 cycles after start.
- Load header at address DEPTH-1 with no halt → err=1, done pulses, no load transaction. Next start clears err.
- rst asserted during the ISSUE of the 2nd instruction → next cycle: all outputs 0, busy=0, pc=0, no done. Restart reruns from address 0 with memory intact.
- prog_we and start pulsed mid-run → both ignored; memory readback (rerun) unchanged. With SINGLE_STEP_EN, no step → stays in PAUSE after instruction 1, outputs 0; one step pulse → exactly one more instruction issues.
